mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single data-memory access port between two requesters: the CPU multicycle controller (requester C) and the debug/program loader (requester L). Memory has synchronous read with 1-cycle latency. C has priority. L gets a bounded starvation guarantee and may lock the port for short bursts. Sits between the control/datapath memory signals and the memory macro; the controller treats `cpu_stall` as a wait condition in any memory-access state.

## Interface
Parameters:
- `ADDR_W`, 16: memory address width.
- `DATA_W`, 16: memory data width.
- `MAX_BURST`, 4: maximum L beats per locked burst (≥1).
- `STARVE_LIM`, 4: consecutive C grants while L waits before L is forced a slot (≥1).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `cpu_req`  in  1  C access request.
- `cpu_we`  in  1  C write (1) / read (0).
- `cpu_addr`  in  ADDR_W  C address.
- `cpu_wdata`  in  DATA_W  C write data.
- `cpu_gnt`  out  1  C access performed this cycle.
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`.
- `cpu_rvalid`  out  1  C read data valid.
- `cpu_rdata`  out  DATA_W  C read data.
- `ldr_req`  in  1  L access request.
- `ldr_we`  in  1  L write/read.
- `ldr_addr`  in  ADDR_W  L address.
- `ldr_wdata`  in  DATA_W  L write data.
- `ldr_last`  in  1  final beat of L burst.
- `ldr_gnt`  out  1  L access performed this cycle.
- `ldr_rvalid`  out  1  L read data valid.
- `ldr_rdata`  out  DATA_W  L read data.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after a read access.

## Operation
Grant is combinational from registered state and the current requests, evaluated each cycle in this priority order:
1. `lock & ldr_req` → L.
2. `cpu_req & ~(ldr_req & starve_cnt==STARVE_LIM)` → C.
3. `ldr_req` → L.
4. Otherwise no grant. `mem_en=0`; `mem_addr`/`mem_wdata` hold their last values (don't-care).

When there is a grant:
- Memory outputs are muxed from the granted requester.
- `mem_en` = 1 and `mem_we` = the granted requester's `we`.
- At most one grant per cycle.

State updates on `posedge clk`:
- `starve_cnt`:
  - +1 (saturating at STARVE_LIM) when C is granted while `ldr_req` = 1.
  - Cleared when L is granted or `ldr_req` = 0.
- Burst lock (`lock`, `beat_cnt`):
  - On an L grant with `ldr_last` = 0 and `beat_cnt+1 < MAX_BURST`: `lock` = 1 and `beat_cnt` +1.
  - On an L grant with `ldr_last` = 1, or `beat_cnt+1 == MAX_BURST`: `lock` = 0 and `beat_cnt` = 0.
  - When `lock` = 1 and `ldr_req` = 0: `lock` = 0 and `beat_cnt` = 0. The burst is abandoned.
  - With MAX_BURST = 1, lock never asserts.
- Read return:
  - `rd_owner` and `rd_pend` are registered on a granted read.
  - The next cycle, the owner's `rvalid` = 1 and its `rdata` = `mem_rdata`.
  - The other requester's `rvalid` = 0.
  - `rdata` is don't-care when `rvalid` = 0.
- Writes produce no `rvalid`.

Requester rules:
- A requester holds `req`, `we`, `addr` and `wdata` stable until it sees its `gnt`.
- Deasserting `req` before `gnt` is a legal abort.

## Timing
- Reset values:
  - All `gnt`, `rvalid`, `mem_en`, `mem_we` = 0.
  - `lock` = 0; `beat_cnt` = `starve_cnt` = 0; `rd_pend` = 0.
  - `mem_addr`/`mem_wdata` = 0.
- Grant latency: 0 cycles (same cycle as `req` when it wins).
- Read data latency: 1 cycle after grant.
- Back-to-back reads from either requester are sustained at one per cycle.
- Simultaneous first requests with `lock` = 0 and `starve_cnt` < STARVE_LIM: C wins.
- Worst-case L wait without lock: STARVE_LIM cycles.
- Worst-case C wait: MAX_BURST cycles.
- Reset mid-burst or with a read pending:
  - Lock and counters clear immediately.
  - No `rvalid` is produced for the aborted read.

## Structure
- Shared package `jala_pkg`: `ADDR_W`/`DATA_W` defaults, owner enum `{OWN_CPU, OWN_LDR}`.
- One natural sub-module, `arb_fairness`: holds `starve_cnt`, `lock` and `beat_cnt`; outputs `force_ldr` and `lock`.
- Top-level muxing and read-return tracking stay in `mem_arbiter`.

## Test plan
- Reset, then a C-only read of 0x0010 with memory holding 0xBEEF → `cpu_gnt` = 1 the same cycle, `mem_addr` = 0x0010, `mem_we` = 0. Next cycle `cpu_rvalid` = 1, `cpu_rdata` = 0xBEEF, `ldr_rvalid` = 0.
- C and L both assert a first write in the same cycle → C granted that cycle, L granted the next. `starve_cnt` = 1, then 0.
- C and L requesting continuously, STARVE_LIM = 4, L single beats (`ldr_last` = 1) → grant pattern C, C, C, C, L repeating.
- L 3-beat burst (`ldr_last` on beat 3), C asserts during beat 2 → L gets 3 consecutive grants, C granted on cycle 4. `lock` = 0 afterwards.
- L holds `req` with `ldr_last` = 0, MAX_BURST = 4, C requesting → L 4 beats, then C granted, then L resumes.
- Assert `rst` low during beat 2 of an L read burst → outputs reach reset values asynchronously. After release, C granted first on a simultaneous request and no stale `ldr_rvalid` appears.

Source files
------------

// File: rtl/jala_pkg.sv
// rtl/jala_pkg.sv - shared widths, read-owner encoding and counter sizing for the memory arbiter
package jala_pkg;

  // Default memory port widths used by the arbiter and its neighbours
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  // Which requester a pending read belongs to
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_e;

  // Bits needed for a counter that must be able to hold max_val itself
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_fairness.sv
// rtl/arb_fairness.sv - loader starvation counter and burst lock for the memory arbiter
module arb_fairness
  import jala_pkg::*;
#(
  parameter int MAX_BURST  = 4,
  parameter int STARVE_LIM = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ldr_req,
  input  logic ldr_last,
  input  logic cpu_gnt,
  input  logic ldr_gnt,
  output logic force_ldr,
  output logic lock
);

  localparam int SW = cnt_width(STARVE_LIM);
  localparam int BW = cnt_width(MAX_BURST);

  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
  localparam logic [BW:0]   BURST_MAX  = (BW+1)'(MAX_BURST);

  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] beat_cnt;
  logic [BW:0]   beat_next;
  logic          burst_more;

  // One bit wider than beat_cnt so the compare against MAX_BURST cannot wrap
  assign beat_next  = {1'b0, beat_cnt} + {{BW{1'b0}}, 1'b1};

  // Stay locked only if the loader says more beats follow and the burst cap allows it
  assign burst_more = ~ldr_last & (beat_next < BURST_MAX);

  // The loader has watched STARVE_LIM CPU grants go by and must win this cycle
  assign force_ldr  = ldr_req & (starve_cnt == STARVE_MAX);

  // Count CPU grants taken while the loader waits; any loader grant or idle loader forgives it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (cpu_gnt & ldr_req) begin
      if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end else if (ldr_gnt | ~ldr_req) begin
      starve_cnt <= '0;
    end
  end

  // Track loader burst beats; lock holds the port until the last beat, the cap, or an abandon
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock     <= 1'b0;
      beat_cnt <= '0;
    end else if (ldr_gnt) begin
      if (burst_more) begin
        lock     <= 1'b1;
        beat_cnt <= beat_next[BW-1:0];
      end else begin
        lock     <= 1'b0;
        beat_cnt <= '0;
      end
    end else if (lock & ~ldr_req) begin
      lock     <= 1'b0;
      beat_cnt <= '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the data-memory port between the CPU controller and the loader
module mem_arbiter
  import jala_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_BURST  = 4,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic              ldr_last,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              lock;
  logic              force_ldr;
  logic              cpu_win;
  logic              ldr_win;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_pend;
  owner_e            rd_owner;

  arb_fairness #(
    .MAX_BURST (MAX_BURST),
    .STARVE_LIM(STARVE_LIM)
  ) u_fairness (
    .clk      (clk),
    .rst      (rst),
    .ldr_req  (ldr_req),
    .ldr_last (ldr_last),
    .cpu_gnt  (cpu_win),
    .ldr_gnt  (ldr_win),
    .force_ldr(force_ldr),
    .lock     (lock)
  );

  // Pick at most one winner: locked burst, then CPU unless the loader is starving, then loader.
  // Grants are held off while reset is asserted so the port is quiet immediately.
  always_comb begin
    cpu_win = 1'b0;
    ldr_win = 1'b0;
    if (rst) begin
      if (lock & ldr_req) begin
        ldr_win = 1'b1;
      end else if (cpu_req & ~force_ldr) begin
        cpu_win = 1'b1;
      end else if (ldr_req) begin
        ldr_win = 1'b1;
      end
    end
  end

  assign cpu_gnt   = cpu_win;
  assign ldr_gnt   = ldr_win;
  assign cpu_stall = cpu_req & ~cpu_win;

  // Steer the winner onto the memory port; an idle port repeats the last address and data
  always_comb begin
    mem_en    = cpu_win | ldr_win;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (ldr_win) begin
      mem_we    = ldr_we;
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
    end else if (cpu_win) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // Remember the last driven address and data so idle cycles do not toggle the macro inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (mem_en) begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
    end
  end

  // Note who issued this cycle's read so the data returned next cycle goes to the right side
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend  <= 1'b0;
      rd_owner <= OWN_CPU;
    end else begin
      rd_pend <= mem_en & ~mem_we;
      if (mem_en) begin
        rd_owner <= ldr_win ? OWN_LDR : OWN_CPU;
      end
    end
  end

  assign cpu_rvalid = rd_pend & (rd_owner == OWN_CPU);
  assign ldr_rvalid = rd_pend & (rd_owner == OWN_LDR);
  assign cpu_rdata  = mem_rdata;
  assign ldr_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed checks of mem_arbiter against a behavioural model
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MB = 4;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          ldr_req = 1'b0, ldr_we = 1'b0, ldr_last = 1'b0;
  logic [AW-1:0] ldr_addr = '0;
  logic [DW-1:0] ldr_wdata = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          cpu_gnt, cpu_stall, cpu_rvalid, ldr_gnt, ldr_rvalid;
  logic [DW-1:0] cpu_rdata, ldr_rdata, mem_wdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .STARVE_LIM(SL)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_last(ldr_last), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // memory macro: synchronous read with one cycle latency
  logic [DW-1:0] mem_arr [0:255] = '{default: '0};
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr[7:0]];
    end
  end

  // behavioural model state
  logic [DW-1:0] ref_mem [0:255] = '{default: '0};
  int            m_streak = 0;    // CPU grants in a row while the loader waited
  int            m_beats  = 0;    // loader beats granted in the current burst
  logic [AW-1:0] m_last_addr = '0;
  bit            m_rd_pend = 0, m_rd_ldr = 0;
  logic [DW-1:0] m_rd_data = '0;
  int            cpu_wait = 0, ldr_wait = 0;
  int            win = 0;         // 0 none, 1 CPU, 2 loader in the last stepped cycle

  int vectors = 0, miscompares = 0;

  bit            s_cg, s_lg, s_crv, s_lrv, s_we;
  logic [DW-1:0] s_crd;
  logic [AW-1:0] s_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // one cycle: compare at negedge against the model, advance the model, return at posedge+1
  task automatic step();
    int            w;
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clk);
    if (m_beats > 0 && ldr_req)                 w = 2;
    else if (cpu_req && !(ldr_req && m_streak >= SL)) w = 1;
    else if (ldr_req)                            w = 2;
    else                                         w = 0;

    chk("cpu_gnt", cpu_gnt, w == 1);
    chk("ldr_gnt", ldr_gnt, w == 2);
    chk("cpu_stall", cpu_stall, cpu_req && w != 1);
    chk("mem_en", mem_en, w != 0);
    we = (w == 1) ? cpu_we : ldr_we;
    a  = (w == 1) ? cpu_addr : ldr_addr;
    d  = (w == 1) ? cpu_wdata : ldr_wdata;
    if (w != 0) begin
      chk("mem_we", mem_we, we);
      chk("mem_addr", mem_addr, a);
      if (we) chk("mem_wdata", mem_wdata, d);
    end else begin
      chk("mem_addr_hold", mem_addr, m_last_addr);
    end
    chk("cpu_rvalid", cpu_rvalid, m_rd_pend && !m_rd_ldr);
    chk("ldr_rvalid", ldr_rvalid, m_rd_pend && m_rd_ldr);
    if (m_rd_pend) begin
      if (m_rd_ldr) chk("ldr_rdata", ldr_rdata, m_rd_data);
      else          chk("cpu_rdata", cpu_rdata, m_rd_data);
    end

    cpu_wait = (cpu_req && w != 1) ? cpu_wait + 1 : 0;
    ldr_wait = (ldr_req && w != 2) ? ldr_wait + 1 : 0;
    if (cpu_wait > 0) chk("cpu_wait_bound", cpu_wait <= MB, 1);
    if (ldr_wait > 0) chk("ldr_wait_bound", ldr_wait <= SL, 1);

    s_cg = cpu_gnt; s_lg = ldr_gnt; s_crv = cpu_rvalid; s_lrv = ldr_rvalid;
    s_crd = cpu_rdata; s_addr = mem_addr; s_we = mem_we;

    m_rd_pend = 0;
    if (w != 0) begin
      m_last_addr = a;
      if (we) ref_mem[a[7:0]] = d;
      else begin
        m_rd_pend = 1;
        m_rd_ldr  = (w == 2);
        m_rd_data = ref_mem[a[7:0]];
      end
    end
    if (w == 1 && ldr_req)      m_streak = (m_streak + 1 > SL) ? SL : m_streak + 1;
    else if (w == 2 || !ldr_req) m_streak = 0;
    if (w == 2)        m_beats = (!ldr_last && m_beats + 1 < MB) ? m_beats + 1 : 0;
    else if (!ldr_req) m_beats = 0;
    win = w;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_ldr(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit last);
    ldr_req = req; ldr_we = we; ldr_addr = a; ldr_wdata = d; ldr_last = last;
  endtask

  // assert reset between clock edges; outputs must be quiet before any edge arrives
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_ldr_gnt", ldr_gnt, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_ldr_rvalid", ldr_rvalid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    set_cpu(0, 0, '0, '0);
    set_ldr(0, 0, '0, '0, 0);
    m_streak = 0; m_beats = 0; m_rd_pend = 0; m_last_addr = '0;
    cpu_wait = 0; ldr_wait = 0; win = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  bit exp_rr [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  bit exp_lk [9]  = '{0, 0, 0, 1, 1, 1, 1, 0, 0};

  initial begin
    #1;
    do_reset();

    // C-only read of 0x0010 holding 0xBEEF (loaded by a loader write first)
    set_ldr(1, 1, 16'h0010, 16'hBEEF, 1);
    step();
    chk("preload_ldr_gnt", s_lg, 1);
    set_ldr(0, 0, '0, '0, 0);
    set_cpu(1, 0, 16'h0010, '0);
    step();
    chk("t1_cpu_gnt", s_cg, 1);
    chk("t1_mem_addr", s_addr, 16'h0010);
    chk("t1_mem_we", s_we, 0);
    set_cpu(0, 0, '0, '0);
    step();
    chk("t1_cpu_rvalid", s_crv, 1);
    chk("t1_cpu_rdata", s_crd, 16'hBEEF);
    chk("t1_ldr_rvalid", s_lrv, 0);

    // simultaneous first writes: C then L
    do_reset();
    set_cpu(1, 1, 16'h0020, 16'h1111);
    set_ldr(1, 1, 16'h0021, 16'h2222, 1);
    step();
    chk("t2_first_cpu", s_cg, 1);
    chk("t2_first_ldr", s_lg, 0);
    set_cpu(0, 0, '0, '0);
    step();
    chk("t2_second_ldr", s_lg, 1);
    set_ldr(0, 0, '0, '0, 0);
    step();

    // continuous requests, single loader beats: C C C C L repeating
    do_reset();
    set_cpu(1, 0, 16'h0003, '0);
    set_ldr(1, 0, 16'h0004, '0, 1);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t3_pattern_cpu", s_cg, exp_rr[k]);
      chk("t3_pattern_ldr", s_lg, !exp_rr[k]);
    end

    // loader 3-beat burst with C arriving on beat 2
    do_reset();
    set_ldr(1, 0, 16'h0010, '0, 0);
    step();
    chk("t4_beat1", s_lg, 1);
    set_cpu(1, 0, 16'h0005, '0);
    set_ldr(1, 0, 16'h0011, '0, 0);
    step();
    chk("t4_beat2", s_lg, 1);
    set_ldr(1, 0, 16'h0012, '0, 1);
    step();
    chk("t4_beat3", s_lg, 1);
    chk("t4_beat3_cpu", s_cg, 0);
    set_ldr(0, 0, '0, '0, 0);
    step();
    chk("t4_cpu_after", s_cg, 1);
    set_cpu(1, 0, 16'h0006, '0);
    set_ldr(1, 0, 16'h0013, '0, 1);
    step();
    chk("t4_unlocked_cpu_wins", s_cg, 1);
    set_cpu(0, 0, '0, '0);
    set_ldr(0, 0, '0, '0, 0);
    step();

    // loader never sets last: burst capped at MAX_BURST, C then gets its turn
    do_reset();
    set_ldr(1, 0, 16'h0008, '0, 0);
    step();
    chk("t5_first", s_lg, 1);
    set_cpu(1, 0, 16'h0009, '0);
    for (int k = 0; k < 9; k++) begin
      step();
      chk("t5_pattern_cpu", s_cg, exp_lk[k]);
      chk("t5_pattern_ldr", s_lg, !exp_lk[k]);
    end

    // reset during beat 2 of a loader read burst
    do_reset();
    set_ldr(1, 0, 16'h0010, '0, 0);
    step();
    set_ldr(1, 0, 16'h0011, '0, 0);
    step();
    chk("t6_beat2", s_lg, 1);
    do_reset();
    set_cpu(1, 0, 16'h0001, '0);
    set_ldr(1, 0, 16'h0002, '0, 0);
    step();
    chk("t6_cpu_first", s_cg, 1);
    chk("t6_no_stale_rvalid", s_lrv, 0);
    set_cpu(0, 0, '0, '0);
    set_ldr(0, 0, '0, '0, 0);
    step();

    // randomized traffic from two well-behaved requesters with occasional aborts and resets
    for (int i = 0; i < 4000; i++) begin
      if (i % 900 == 899) do_reset();
      if (!cpu_req || win == 1) begin
        if ($urandom_range(3) != 0)
          set_cpu(1, $urandom_range(1), AW'($urandom_range(31)), DW'($urandom));
        else
          cpu_req = 1'b0;
      end else if ($urandom_range(15) == 0) begin
        cpu_req = 1'b0;
      end
      if (!ldr_req || win == 2) begin
        if ($urandom_range(4) != 0)
          set_ldr(1, $urandom_range(1), AW'($urandom_range(31)), DW'($urandom),
                  $urandom_range(3) == 0);
        else
          ldr_req = 1'b0;
      end else if ($urandom_range(15) == 0) begin
        ldr_req = 1'b0;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
